// File: rtl/div_pkg.sv
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the sequential divider
//                (FSM state encoding, default operand width, counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  // Default operand/result width of the divider.
  localparam int DIV_WIDTH = 32;

  // Iteration counter must hold the value DIV_WIDTH itself.
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage : div_pkg

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division iteration on unsigned
//                magnitudes: shift {rem,quot} left, trial-subtract the divisor,
//                keep the difference and set the quotient LSB when it fits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quot
);

  logic [WIDTH:0] rem_sh;
  logic           fits;

  // Shift in the next dividend bit and decide whether the divisor fits.
  // The shifted remainder needs WIDTH+1 bits because the divisor magnitude
  // may use the full WIDTH bits (unsigned mode). When the divisor fits, the
  // difference is below the divisor, so it is exact modulo 2^WIDTH.
  always_comb begin
    rem_sh = {i_rem, i_quot[WIDTH-1]};
    fits   = (rem_sh >= {1'b0, i_divisor});
    o_rem  = fits ? (rem_sh[WIDTH-1:0] - i_divisor) : rem_sh[WIDTH-1:0];
    o_quot = {i_quot[WIDTH-2:0], fits};
  end

endmodule : div_step

`default_nettype wire

// File: rtl/div_seq.sv
// ============================================================================
//  Module      : div_seq
//  Description : Sequential signed 32-bit divider (DIV) for the multicycle
//                MIPS core. Start/Busy/Done handshake, restoring algorithm,
//                one quotient bit per cycle, Lo = quotient, Hi = remainder,
//                DivZero pulse with Done on a zero divisor.
//                Optional macro DIV_UNSIGNED_EN adds the Unsigned input (DIVU).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
`ifdef DIV_UNSIGNED_EN
  input  logic             Unsigned,
`endif
  input  logic [WIDTH-1:0] Dividendo,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] Hi,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int C_CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH + 1);

  div_state_e         state_q, state_d;
  logic [C_CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   rem_q,   rem_d;
  logic [WIDTH-1:0]   quot_q,  quot_d;
  logic [WIDTH-1:0]   dvs_q,   dvs_d;
  logic               qneg_q,  qneg_d;
  logic               rneg_q,  rneg_d;
  logic               dz_q,    dz_d;
  logic [WIDTH-1:0]   lo_q,    lo_d;
  logic [WIDTH-1:0]   hi_q,    hi_d;

  logic               is_uns;
  logic               a_sgn;
  logic               b_sgn;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quot;

`ifdef DIV_UNSIGNED_EN
  assign is_uns = Unsigned;
`else
  assign is_uns = 1'b0;
`endif

  // Operand magnitudes and signs; unsigned operations bypass sign handling.
  always_comb begin
    a_sgn = Dividendo[WIDTH-1] & ~is_uns;
    b_sgn = Divisor[WIDTH-1]   & ~is_uns;
    a_abs = a_sgn ? (-Dividendo) : Dividendo;
    b_abs = b_sgn ? (-Divisor)   : Divisor;
  end

  div_step #(
    .WIDTH     (WIDTH)
  ) u_step (
    .i_rem     (rem_q),
    .i_quot    (quot_q),
    .i_divisor (dvs_q),
    .o_rem     (step_rem),
    .o_quot    (step_quot)
  );

  // State and datapath registers, cleared by synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  // Next-state logic, datapath updates and handshake outputs.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    Busy    = 1'b0;
    Done    = 1'b0;
    DivZero = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          dz_d = (Divisor == '0);
          if (Divisor == '0) begin
            // No iteration; Lo/Hi keep their previous contents.
            state_d = DONE;
          end else begin
            rem_d   = '0;
            quot_d  = a_abs;
            dvs_d   = b_abs;
            qneg_d  = a_sgn ^ b_sgn;
            rneg_d  = a_sgn;
            count_d = C_CNT_W'(WIDTH);
            state_d = RUN;
          end
        end
      end

      RUN: begin
        Busy    = 1'b1;
        rem_d   = step_rem;
        quot_d  = step_quot;
        count_d = count_q - 1'b1;
        if (count_q == C_CNT_W'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        // Truncating division: remainder follows the dividend's sign.
        Busy    = 1'b1;
        lo_d    = qneg_q ? (-quot_q) : quot_q;
        hi_d    = rneg_q ? (-rem_q)  : rem_q;
        state_d = DONE;
      end

      DONE: begin
        Done    = 1'b1;
        DivZero = dz_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Lo = lo_q;
  assign Hi = hi_q;

endmodule : div_seq

`default_nettype wire

// File: tb/tb_div_seq.sv
// ============================================================================
//  Module      : tb_div_seq
//  Description : Directed self-checking bench for div_seq. Each division is
//                started on a known cycle and its result, latency, Busy span
//                and DivZero flag are compared with hand-computed values.
//                Unsigned-mode vectors are built only with DIV_UNSIGNED_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_seq;

  logic        Clk       = 1'b0;
  logic        Reset     = 1'b1;
  logic        Start     = 1'b0;
  logic        Uns       = 1'b0;
  logic [31:0] Dividendo = '0;
  logic [31:0] Divisor   = '0;
  logic [31:0] Lo;
  logic [31:0] Hi;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  int n_checks = 0;
  int n_errors = 0;

  div_seq #(
    .WIDTH     (32)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
`ifdef DIV_UNSIGNED_EN
    .Unsigned  (Uns),
`endif
    .Dividendo (Dividendo),
    .Divisor   (Divisor),
    .Lo        (Lo),
    .Hi        (Hi),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Start one division at cycle 0; optionally raise a stray Start (50/5)
  // during cycle s2. Checks latency, Busy span, results and the pulse shape.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic uns, input int s2,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input logic exp_dz, input int exp_lat);
    int cyc;
    int busy_cnt;
    cyc      = 0;
    busy_cnt = 0;
    @(negedge Clk);
    Start     = 1'b1;
    Uns       = uns;
    Dividendo = a;
    Divisor   = b;
    @(posedge Clk);
    #1;
    cyc       = 1;
    Start     = 1'b0;
    Uns       = ~uns;
    Dividendo = 32'hDEAD_BEEF;
    Divisor   = 32'h0000_0003;
    while (Done !== 1'b1 && cyc < 100) begin
      if (Busy === 1'b1) busy_cnt++;
      Start = (cyc == s2);
      if (cyc == s2) begin
        Dividendo = 32'd50;
        Divisor   = 32'd5;
      end
      @(posedge Clk);
      #1;
      cyc++;
    end
    Start = 1'b0;
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat - 1);
    check({tag, "_busy_at_done"}, {31'd0, Busy}, 32'd0);
    check({tag, "_lo"}, Lo, exp_lo);
    check({tag, "_hi"}, Hi, exp_hi);
    check({tag, "_divzero"}, {31'd0, DivZero}, {31'd0, exp_dz});
    @(posedge Clk);
    #1;
    check({tag, "_done_pulse"}, {30'd0, Done, DivZero}, 32'd0);
    repeat (3) @(posedge Clk);
    #1;
    check({tag, "_lo_hold"}, Lo, exp_lo);
    check({tag, "_hi_hold"}, Hi, exp_hi);
  endtask

  initial begin
    int cyc;
    int done_seen;

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check("reset_lo", Lo, 32'd0);
    check("reset_hi", Hi, 32'd0);
    check("reset_flags", {29'd0, Busy, Done, DivZero}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    do_div("d100_7",   32'd100,       32'd7,          1'b0, 0, 32'd14,        32'd2,         1'b0, 34);
    do_div("dm7_2",    32'hFFFF_FFF9, 32'd2,          1'b0, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
    do_div("d7_m2",    32'd7,         32'hFFFF_FFFE,  1'b0, 0, 32'hFFFF_FFFD, 32'd1,         1'b0, 34);
    do_div("dm100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9,  1'b0, 0, 32'd14,        32'hFFFF_FFFE, 1'b0, 34);
    do_div("d0_5",     32'd0,         32'd5,          1'b0, 0, 32'd0,         32'd0,         1'b0, 34);
    do_div("d59_10",   32'd59,        32'd10,         1'b0, 0, 32'd5,         32'd9,         1'b0, 34);
    do_div("dzero",    32'd1234,      32'd0,          1'b0, 0, 32'd5,         32'd9,         1'b1, 1);
    do_div("ovf",      32'h8000_0000, 32'hFFFF_FFFF,  1'b0, 0, 32'h8000_0000, 32'd0,         1'b0, 34);
    do_div("restart",  32'd100,       32'd7,          1'b0, 10, 32'd14,       32'd2,         1'b0, 34);
`ifdef DIV_UNSIGNED_EN
    do_div("divu",     32'hFFFF_FFFF, 32'd2,          1'b1, 0, 32'h7FFF_FFFF, 32'd1,         1'b0, 34);
    do_div("div_m1_2", 32'hFFFF_FFFF, 32'd2,          1'b0, 0, 32'd0,         32'hFFFF_FFFF, 1'b0, 34);
`endif

    // Reset in the middle of an operation
    @(negedge Clk);
    Start     = 1'b1;
    Dividendo = 32'd100;
    Divisor   = 32'd7;
    @(posedge Clk);
    #1;
    cyc   = 1;
    Start = 1'b0;
    while (cyc < 10) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    check("midrst_lo", Lo, 32'd0);
    check("midrst_hi", Hi, 32'd0);
    check("midrst_flags", {29'd0, Busy, Done, DivZero}, 32'd0);
    done_seen = 0;
    repeat (40) begin
      @(posedge Clk);
      #1;
      if (Done === 1'b1 || Busy === 1'b1) done_seen++;
    end
    check("midrst_no_done", done_seen, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_div_seq

`default_nettype wire

// File: doc/div_seq.md
Name: div_seq

Overview:
- Sequential 32-bit integer divider for the multicycle MIPS core; executes DIV (and optionally DIVU).
- Sits beside the multiplier: consumes register A (dividend) and register B (divisor) outputs, produces quotient/remainder for the Lo/Hi registers (read by MFLO/MFHI).
- Driven by the controller through a Start/Busy/Done handshake; flags divide-by-zero so the controller can branch to the exception path.

Parameters:
WIDTH, 32, operand/result width in bits.

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
Start  input  1  request a division; sampled only in IDLE
Dividendo  input  WIDTH  dividend (register A output)
Divisor  input  WIDTH  divisor (register B output)
Lo  output  WIDTH  quotient
Hi  output  WIDTH  remainder
Busy  output  1  high from the cycle after an accepted Start until Done
Done  output  1  one-cycle pulse; Lo/Hi valid from this cycle on
DivZero  output  1  one-cycle pulse coincident with Done when Divisor was 0

Behaviour:
- One clock, Clk. Reset is synchronous and active-high. All state updates on rising Clk.
- Reset value of every output is 0: Lo, Hi, Busy, Done, DivZero. State goes to IDLE and the iteration counter to 0.
- States:
  - IDLE: Start=1 with Divisor!=0 latches |Dividendo|, |Divisor|, the sign bits and count=WIDTH, then goes to RUN. Start=1 with Divisor==0 goes to DONE and marks divide-by-zero. Start=0 stays in IDLE.
  - RUN: one restoring step per cycle. Shift {rem,quot} left by 1; trial = rem - |divisor| in WIDTH+1 bits. If trial is non-negative, rem=trial and the quotient LSB is 1, else the LSB is 0. count decrements; after the cycle where count reaches 1, go to FIX.
  - FIX: apply signs. Quotient is negated if the dividend and divisor signs differ; remainder takes the sign of the dividend (truncate toward zero). Load Lo/Hi, go to DONE.
  - DONE: Done=1 for this cycle only, DivZero=1 if marked; return to IDLE.
- Latency: Start sampled at edge 0 gives Done high in cycle WIDTH+2 (34). Divide-by-zero gives Done in cycle 1.
- Divide-by-zero: Lo and Hi keep their previous values; no iteration runs.
- Overflow case: 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0. Result wraps and no flag is raised.
- Start while Busy is ignored, with no effect on the operation in flight. Start asserted in the DONE cycle is also ignored.
- Operands are captured at acceptance; Dividendo/Divisor may change afterwards without effect.
- Lo/Hi change only in FIX and hold otherwise, so MFHI/MFLO after Done are stable indefinitely.
- Reset mid-operation aborts at the next edge: IDLE, all outputs 0, no Done pulse.

Optional Feature:
- Macro DIV_UNSIGNED_EN.
- When defined: adds input port Unsigned (1 bit), sampled with Start. Unsigned=1 skips absolute value and sign fixup (DIVU semantics), with identical latency.
- When undefined: no Unsigned port; all operations are signed.

Decomposition:
- Package div_pkg holds:
  - the state enum {IDLE, RUN, FIX, DONE}, 2 bits;
  - localparam DIV_WIDTH=32;
  - the counter width $clog2(WIDTH+1).
- One combinational sub-module, div_step: inputs are the current rem, quot and divisor; outputs are the next rem and quot for a single restoring iteration. It keeps the RUN datapath unit-testable.

Test Plan:
- 100 / 7, Start at cycle 0 -> Done at cycle 34, Lo=14, Hi=2, DivZero=0; Busy high cycles 1-33.
- -7 / 2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); 7 / -2 -> Lo=-3, Hi=1.
- Lo=5/Hi=9 preloaded from a prior division, then 1234 / 0 -> Done and DivZero pulse at cycle 1, Lo=5, Hi=9 unchanged.
- 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0, DivZero=0.
- 100 / 7 started, second Start (50 / 5) at cycle 10 ignored -> result 14 rem 2. In a separate run, Reset at cycle 10 -> all outputs 0 next cycle and no Done.
- With DIV_UNSIGNED_EN, Unsigned=1: 0xFFFFFFFF / 2 -> Lo=0x7FFFFFFF, Hi=1. Unsigned=0, same operands -> Lo=0, Hi=0xFFFFFFFF.
